bcpu_ibus_port: RTL and testbench

BCPU_IBUS_PORT -- requirements
Module: bcpu_ibus_port

---
 rtl/bcpu_defs.sv | 17 +
 rtl/bcpu_sync2.sv | 26 ++
 rtl/bcpu_ibus_port.sv | 154 +++++++++++++++
 tb/tb_bcpu_ibus_port.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcpu_defs.sv
// Shared types for the BCPU IBUS port block: bus operation codes and port FSM states.
package bcpu_defs;

    typedef enum logic [1:0] {
        READ   = 2'd0,
        WRITE  = 2'd1,
        WAITE  = 2'd2,
        WAITNE = 2'd3
    } bus_wr_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } ibus_state_t;

endpackage

// File: rtl/bcpu_sync2.sv
// Two-flop synchronizer for a DATA_WIDTH-bit bus, synchronous active-high clear.
module bcpu_sync2 #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic [DATA_WIDTH-1:0] meta_q;
    logic [DATA_WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/bcpu_ibus_port.sv
// IBUS port block: 8 synchronized input ports, 8 masked-write output registers, READ/WRITE/WAITE/WAITNE.
// Optional wait timeout compiled in with `define BCPU_IBUS_WAIT_TIMEOUT_EN.
module bcpu_ibus_port
    import bcpu_defs::*;
#(
    parameter int unsigned           DATA_WIDTH      = 16,
    parameter logic [DATA_WIDTH-1:0] OUT_RESET_VALUE = '0,
    parameter int unsigned           TIMEOUT_CYCLES  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  bus_wr_op_t            req_op,
    input  logic [2:0]            req_port,
    input  logic [DATA_WIDTH-1:0] req_value,
    input  logic [DATA_WIDTH-1:0] req_mask,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  wait_timeout,
    output logic                  busy,
    input  logic [DATA_WIDTH-1:0] port_in  [8],
    output logic [DATA_WIDTH-1:0] port_out [8]
);

    ibus_state_t           state_q, state_d;
    bus_wr_op_t            op_q, op_d;
    logic [2:0]            port_q, port_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  to_q, to_d;
    logic [DATA_WIDTH-1:0] port_out_q [8];
    logic [DATA_WIDTH-1:0] port_out_d [8];
    logic [DATA_WIDTH-1:0] sin [8];
    logic                  eq;
    logic                  hit;

    for (genvar g = 0; g < 8; g++) begin : g_sync
        bcpu_sync2 #(.DATA_WIDTH(DATA_WIDTH)) u_sync (
            .clk   (clk),
            .reset (reset),
            .d_i   (port_in[g]),
            .q_o   (sin[g])
        );
    end

`ifdef BCPU_IBUS_WAIT_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign eq  = (sin[port_q] & mask_q) == (value_q & mask_q);
    assign hit = (op_q == WAITE) ? eq : !eq;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        port_d     = port_q;
        value_d    = value_q;
        mask_d     = mask_q;
        rd_data_d  = rd_data_q;
        to_d       = to_q;
        port_out_d = port_out_q;
`ifdef BCPU_IBUS_WAIT_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                to_d = 1'b0;
                if (req_valid) begin
                    case (req_op)
                        READ: begin
                            rd_data_d = sin[req_port] & req_mask;
                            state_d   = ACK;
                        end
                        WRITE: begin
                            port_out_d[req_port] = (port_out_q[req_port] & ~req_mask) |
                                                   (req_value & req_mask);
                            state_d = ACK;
                        end
                        default: begin
                            op_d    = req_op;
                            port_d  = req_port;
                            value_d = req_value;
                            mask_d  = req_mask;
                            state_d = WAIT;
`ifdef BCPU_IBUS_WAIT_TIMEOUT_EN
                            cnt_d   = '0;
`endif
                        end
                    endcase
                end
            end
            WAIT: begin
                // A satisfied condition takes priority over an expiring timeout.
                if (hit) begin
                    rd_data_d = '0;
                    to_d      = 1'b0;
                    state_d   = ACK;
                end
`ifdef BCPU_IBUS_WAIT_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rd_data_d = '0;
                    to_d      = 1'b1;
                    state_d   = ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= READ;
            port_q     <= '0;
            value_q    <= '0;
            mask_q     <= '0;
            rd_data_q  <= '0;
            to_q       <= 1'b0;
            port_out_q <= '{default: OUT_RESET_VALUE};
`ifdef BCPU_IBUS_WAIT_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            port_q     <= port_d;
            value_q    <= value_d;
            mask_q     <= mask_d;
            rd_data_q  <= rd_data_d;
            to_q       <= to_d;
            port_out_q <= port_out_d;
`ifdef BCPU_IBUS_WAIT_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign ack          = (state_q == ACK);
    assign busy         = (state_q != IDLE);
    assign rd_data      = rd_data_q;
    assign port_out     = port_out_q;
`ifdef BCPU_IBUS_WAIT_TIMEOUT_EN
    assign wait_timeout = ack & to_q;
`else
    assign wait_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bcpu_ibus_port.sv
// Self-checking bench for bcpu_ibus_port: directed scenarios plus randomized traffic against a behavioural model.
module tb_bcpu_ibus_port;
    import bcpu_defs::*;

    localparam logic [15:0] RV = 16'h0000;
    localparam int          TO = 8;
`ifdef BCPU_IBUS_WAIT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    bus_wr_op_t  req_op = READ;
    logic [2:0]  req_port = '0;
    logic [15:0] req_value = '0;
    logic [15:0] req_mask = '0;
    logic        ack;
    logic [15:0] rd_data;
    logic        wait_timeout;
    logic        busy;
    logic [15:0] port_in  [8];
    logic [15:0] port_out [8];

    always #5 clk = ~clk;

    bcpu_ibus_port #(
        .DATA_WIDTH      (16),
        .OUT_RESET_VALUE (RV),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_port     (req_port),
        .req_value    (req_value),
        .req_mask     (req_mask),
        .ack          (ack),
        .rd_data      (rd_data),
        .wait_timeout (wait_timeout),
        .busy         (busy),
        .port_in      (port_in),
        .port_out     (port_out)
    );

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a request is either outstanding (waiting), being acknowledged, or absent.
    logic [15:0] m_s1 [8];
    logic [15:0] m_s2 [8];
    logic [15:0] m_out [8];
    logic [15:0] m_rd;
    bit          m_ack, m_to, m_wait;
    bus_wr_op_t  m_op;
    int          m_port, m_age;
    logic [15:0] m_val, m_msk;

    always @(posedge clk) begin : model
        bit nack, nto, cond;
        if (reset) begin
            m_ack = 0; m_to = 0; m_wait = 0; m_rd = '0; m_age = 0;
            for (int i = 0; i < 8; i++) m_out[i] = RV;
        end else begin
            nack = 0; nto = 0;
            if (m_ack) begin
                nack = 0;
            end else if (m_wait) begin
                cond = ((m_s2[m_port] & m_msk) == (m_val & m_msk)) ^ (m_op == WAITNE);
                if (cond) begin
                    nack = 1; m_rd = '0; m_wait = 0;
                end else if (TO_EN && m_age == TO - 1) begin
                    nack = 1; nto = 1; m_rd = '0; m_wait = 0;
                end else begin
                    m_age++;
                end
            end else if (req_valid) begin
                if (req_op == READ) begin
                    m_rd = m_s2[req_port] & req_mask;
                    nack = 1;
                end else if (req_op == WRITE) begin
                    m_out[req_port] = (m_out[req_port] & ~req_mask) | (req_value & req_mask);
                    nack = 1;
                end else begin
                    m_wait = 1; m_op = req_op; m_port = int'(req_port);
                    m_val = req_value; m_msk = req_mask; m_age = 0;
                end
            end
            m_ack = nack;
            m_to  = nto;
        end
        for (int i = 0; i < 8; i++) begin
            m_s2[i] = reset ? 16'h0 : m_s1[i];
            m_s1[i] = reset ? 16'h0 : port_in[i];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ack", 32'(ack), 32'(m_ack));
            chk("busy", 32'(busy), 32'(m_ack | m_wait));
            chk("wait_timeout", 32'(wait_timeout), 32'(m_to));
            chk("rd_data", 32'(rd_data), 32'(m_rd));
            for (int i = 0; i < 8; i++)
                chk($sformatf("port_out%0d", i), 32'(port_out[i]), 32'(m_out[i]));
        end
    end

    task automatic issue(input bus_wr_op_t op, input int p, input logic [15:0] v,
                         input logic [15:0] m, input int maxc, output int lat);
        req_op = op; req_port = 3'(p); req_value = v; req_mask = m; req_valid = 1'b1;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (ack) break;
            if (lat >= maxc) begin
                lat = -1;
                break;
            end
        end
    endtask

    task automatic rand_fields();
        req_op    = bus_wr_op_t'($urandom_range(0, 3));
        req_port  = 3'($urandom_range(0, 7));
        req_value = 16'($urandom);
        if (req_op == WAITE || req_op == WAITNE)
            req_mask = 16'($urandom & $urandom & $urandom);
        else
            req_mask = 16'($urandom);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, n, age;
        for (int i = 0; i < 8; i++) port_in[i] = '0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_out3", 32'(port_out[3]), 32'(RV));

        // Masked write
        issue(WRITE, 3, 16'hABCD, 16'h00FF, 10, lat);
        req_valid = 1'b0;
        chk("wr_lat", lat, 1);
        chk("wr_out3", 32'(port_out[3]), 32'h00CD);
        chk("wr_out2", 32'(port_out[2]), 32'(RV));

        // Read through synchronizer
        port_in[5] = 16'h1234;
        repeat (3) @(negedge clk);
        issue(READ, 5, 16'h0000, 16'h0F0F, 10, lat);
        req_valid = 1'b0;
        chk("rd_lat", lat, 1);
        chk("rd_val", 32'(rd_data), 32'h0204);
        @(negedge clk);
        chk("rd_hold", 32'(rd_data), 32'h0204);

        // WAITE blocked until the input changes
        req_op = WAITE; req_port = 3'd1; req_value = 16'h0001; req_mask = 16'h0001;
        req_valid = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (ack) n++;
        end
        chk("waite_noack", n, 0);
        port_in[1] = 16'h0001;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ack) begin
                lat = c;
                break;
            end
        end
        chk("waite_lat", lat, 3);
        chk("waite_to", 32'(wait_timeout), 0);
        chk("waite_rd", 32'(rd_data), 0);
        req_valid = 1'b0;
        @(negedge clk);

        // WAITNE with zero mask never satisfied
        issue(WAITNE, 0, 16'h0000, 16'h0000, 120, lat);
        req_valid = 1'b0;
`ifdef BCPU_IBUS_WAIT_TIMEOUT_EN
        chk("waitne_to_lat", lat, TO + 1);
        chk("waitne_to_flag", 32'(wait_timeout), 1);
        @(negedge clk);
        issue(WAITE, 2, 16'hFFFF, 16'hFFFF, 5, lat);
        req_valid = 1'b0;
        chk("waite_pending", lat, -1);
`else
        chk("waitne_noack", lat, -1);
        chk("waitne_busy", 32'(busy), 1);
`endif

        // Reset during WAIT aborts silently
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ack", 32'(ack), 0);
        chk("abort_out3", 32'(port_out[3]), 32'(RV));
        repeat (3) @(negedge clk);
        issue(READ, 5, 16'h0000, 16'hFFFF, 10, lat);
        req_valid = 1'b0;
        chk("post_rd_lat", lat, 1);
        chk("post_rd_val", 32'(rd_data), 32'h1234);
        @(negedge clk);

        // Back-to-back writes with req_valid held
        issue(WRITE, 6, 16'hFFFF, 16'h000F, 10, lat);
        chk("b2b_lat0", lat, 1);
        chk("b2b_out0", 32'(port_out[6]), 32'h000F);
        issue(WRITE, 6, 16'h00F0, 16'h00F0, 10, lat);
        chk("b2b_lat1", lat, 2);
        chk("b2b_out1", 32'(port_out[6]), 32'h00FF);
        issue(WRITE, 6, 16'h1234, 16'hFF00, 10, lat);
        req_valid = 1'b0;
        chk("b2b_lat2", lat, 2);
        chk("b2b_out2", 32'(port_out[6]), 32'h12FF);

        // Randomized traffic
        age = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (reset) begin
                reset = 1'b0;
            end else begin
                if ($urandom_range(0, 3) == 0) port_in[$urandom_range(0, 7)] = 16'($urandom);
                if (req_valid) begin
                    age++;
                    if (ack) begin
                        age = 0;
                        if ($urandom_range(0, 1) == 0) req_valid = 1'b0;
                        else rand_fields();
                    end else if (age > 40) begin
                        reset = 1'b1; req_valid = 1'b0; age = 0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    rand_fields();
                    req_valid = 1'b1;
                    age = 0;
                end
                if (!reset && $urandom_range(0, 199) == 0) begin
                    reset = 1'b1; req_valid = 1'b0; age = 0;
                end
            end
        end
        reset = 1'b0;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
